// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: after clock lock, releases per-domain active-low resets in index
// order, DLY_US microseconds apart. Optional lock qualification filter: LOCK_FILTER_EN.
module rst_seq_ctrl #(
   parameter int unsigned N_DOM        = 4,
   parameter int unsigned DLY_US       = 10,
   parameter int unsigned SOFT_HOLD_US = 5,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned LOCK_FILT_US = 3
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic             pluse_us,
   input  logic             pll_locked,
   input  logic             soft_rst_req,
   output logic [N_DOM-1:0] rst_dom_n,
   output logic             seq_done,
   output logic             busy,
   output logic [3:0]       stage
);

   if (N_DOM < 1 || N_DOM > 16) begin : g_bad_n_dom
      $error("rst_seq_ctrl: N_DOM must be 1..16");
   end
   if (DLY_US < 1 || SOFT_HOLD_US < 1 || LOCK_FILT_US < 1) begin : g_bad_us
      $error("rst_seq_ctrl: microsecond parameters must be >= 1");
   end
   if ((DLY_US >> CNT_W) != 0 || (SOFT_HOLD_US >> CNT_W) != 0 ||
       (LOCK_FILT_US >> CNT_W) != 0) begin : g_bad_cnt_w
      $error("rst_seq_ctrl: CNT_W too narrow for the microsecond parameters");
   end

   typedef enum logic [1:0] {
      WAIT_LOCK,
      DELAY,
      DONE,
      SOFT_HOLD
   } state_t;

   state_t             state_q, state_d;
   logic [N_DOM-1:0]   rst_dom_n_q, rst_dom_n_d;
   logic               seq_done_q, seq_done_d;
   logic               busy_q, busy_d;
   logic [3:0]         stage_q, stage_d;
   logic [CNT_W-1:0]   us_cnt_q, us_cnt_d;
   logic               soft_q;
   logic               soft_rise;

   assign soft_rise = soft_rst_req & ~soft_q;

   always_comb begin
      state_d     = state_q;
      rst_dom_n_d = rst_dom_n_q;
      seq_done_d  = seq_done_q;
      stage_d     = stage_q;
      us_cnt_d    = us_cnt_q;

      // Lock loss outranks soft requests and strobes in every state but WAIT_LOCK.
      if (state_q != WAIT_LOCK && !pll_locked) begin
         state_d     = WAIT_LOCK;
         rst_dom_n_d = '0;
         seq_done_d  = 1'b0;
         stage_d     = '0;
         us_cnt_d    = '0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               rst_dom_n_d = '0;
               seq_done_d  = 1'b0;
               stage_d     = '0;
`ifdef LOCK_FILTER_EN
               if (!pll_locked) begin
                  us_cnt_d = '0;
               end else if (pluse_us) begin
                  if (us_cnt_q == CNT_W'(LOCK_FILT_US - 1)) begin
                     state_d  = DELAY;
                     us_cnt_d = '0;
                  end else begin
                     us_cnt_d = us_cnt_q + CNT_W'(1);
                  end
               end
`else
               us_cnt_d = '0;
               if (pll_locked) state_d = DELAY;
`endif
            end
            DELAY: begin
               if (soft_rise) begin
                  state_d     = SOFT_HOLD;
                  rst_dom_n_d = '0;
                  seq_done_d  = 1'b0;
                  stage_d     = '0;
                  us_cnt_d    = '0;
               end else if (pluse_us) begin
                  if (us_cnt_q == CNT_W'(DLY_US - 1)) begin
                     for (int unsigned i = 0; i < N_DOM; i++) begin
                        if (stage_q == 4'(i)) rst_dom_n_d[i] = 1'b1;
                     end
                     us_cnt_d = '0;
                     stage_d  = stage_q + 4'd1;
                     if (stage_q == 4'(N_DOM - 1)) begin
                        state_d    = DONE;
                        seq_done_d = 1'b1;
                     end
                  end else begin
                     us_cnt_d = us_cnt_q + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (soft_rise) begin
                  state_d     = SOFT_HOLD;
                  rst_dom_n_d = '0;
                  seq_done_d  = 1'b0;
                  stage_d     = '0;
                  us_cnt_d    = '0;
               end
            end
            SOFT_HOLD: begin
               if (pluse_us) begin
                  if (us_cnt_q == CNT_W'(SOFT_HOLD_US - 1)) begin
                     state_d  = WAIT_LOCK;
                     us_cnt_d = '0;
                  end else begin
                     us_cnt_d = us_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d     = WAIT_LOCK;
               rst_dom_n_d = '0;
               seq_done_d  = 1'b0;
               stage_d     = '0;
               us_cnt_d    = '0;
            end
         endcase
      end

      busy_d = (state_d != DONE);
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q     <= WAIT_LOCK;
         rst_dom_n_q <= '0;
         seq_done_q  <= 1'b0;
         busy_q      <= 1'b1;
         stage_q     <= '0;
         us_cnt_q    <= '0;
         soft_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_dom_n_q <= rst_dom_n_d;
         seq_done_q  <= seq_done_d;
         busy_q      <= busy_d;
         stage_q     <= stage_d;
         us_cnt_q    <= us_cnt_d;
         soft_q      <= soft_rst_req;
      end
   end

   assign rst_dom_n = rst_dom_n_q;
   assign seq_done  = seq_done_q;
   assign busy      = busy_q;
   assign stage     = stage_q;

endmodule
